// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - PLL retune sequencer driving the reconfig core management port
module pll_reconfig_ctrl #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int POLL_MAX     = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [17:0]       cfg_n,
    input  logic [17:0]       cfg_m,
    input  logic [17:0]       cfg_c0,
    input  logic [31:0]       cfg_k,
    input  logic              cfg_frac_en,
    output logic [ADDR_W-1:0] mgmt_address,
    output logic [DATA_W-1:0] mgmt_writedata,
    output logic              mgmt_write,
    output logic              mgmt_read,
    input  logic [DATA_W-1:0] mgmt_readdata,
    input  logic              mgmt_waitrequest,
    input  logic              pll_locked,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] A_MODE   = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(8'h01);
    localparam logic [ADDR_W-1:0] A_START  = ADDR_W'(8'h02);
    localparam logic [ADDR_W-1:0] A_N      = ADDR_W'(8'h03);
    localparam logic [ADDR_W-1:0] A_M      = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_C      = ADDR_W'(8'h05);
    localparam logic [ADDR_W-1:0] A_K      = ADDR_W'(8'h07);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_N,
        S_WR_M,
        S_WR_C0,
        S_WR_K,
        S_WR_START,
        S_RD_STATUS,
        S_WAIT_LOCK,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              read_q, read_d;
    logic [PW-1:0]     poll_cnt_q, poll_cnt_d;
    logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [17:0]       n_q, n_d, m_q, m_d, c0_q, c0_d;
    logic [31:0]       k_q, k_d;
    logic              frac_q, frac_d;
    logic              lock_meta_q, lock_sync_q;

    logic              is_wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    state_t            wr_next;

    // Only bit 0 of the status word carries meaning.
    logic unused_rdata;
    assign unused_rdata = ^mgmt_readdata[DATA_W-1:1];

    // Two-flop synchronizer for the lock indication coming from the PLL domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Per-state write target: address, payload and the state that follows it.
    always_comb begin
        is_wr   = 1'b1;
        wr_addr = A_MODE;
        wr_data = 32'd0;
        wr_next = S_IDLE;
        case (state_q)
            S_WR_MODE:  begin wr_addr = A_MODE;  wr_data = 32'd1;                  wr_next = S_WR_N;  end
            S_WR_N:     begin wr_addr = A_N;     wr_data = {14'd0, n_q};           wr_next = S_WR_M;  end
            S_WR_M:     begin wr_addr = A_M;     wr_data = {14'd0, m_q};           wr_next = S_WR_C0; end
            S_WR_C0:    begin
                wr_addr = A_C;
                wr_data = {9'd0, 5'd0, c0_q};
                wr_next = frac_q ? S_WR_K : S_WR_START;
            end
            S_WR_K:     begin wr_addr = A_K;     wr_data = k_q;                    wr_next = S_WR_START;  end
            S_WR_START: begin wr_addr = A_START; wr_data = 32'd0;                  wr_next = S_RD_STATUS; end
            default:    is_wr = 1'b0;
        endcase
    end

    // Sequencer next-state: start acceptance, bus handshakes, polling and lock wait.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        read_d     = read_q;
        poll_cnt_d = poll_cnt_q;
        lock_cnt_d = lock_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        n_d        = n_q;
        m_d        = m_q;
        c0_d       = c0_q;
        k_d        = k_q;
        frac_d     = frac_q;

        if (is_wr) begin
            // Entry cycle leaves the bus idle, which also spaces back-to-back writes.
            if (!write_q) begin
                addr_d  = wr_addr;
                wdata_d = DATA_W'(wr_data);
                write_d = 1'b1;
            end else if (!mgmt_waitrequest) begin
                write_d = 1'b0;
                state_d = wr_next;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_d        = cfg_n;
                        m_d        = cfg_m;
                        c0_d       = cfg_c0;
                        k_d        = cfg_k;
                        frac_d     = cfg_frac_en;
                        busy_d     = 1'b1;
                        err_d      = 1'b0;
                        err_code_d = 2'b00;
                        poll_cnt_d = '0;
                        lock_cnt_d = '0;
                        state_d    = S_WR_MODE;
                    end
                end
                S_RD_STATUS: begin
                    if (!read_q) begin
                        addr_d = A_STATUS;
                        read_d = 1'b1;
                    end else if (!mgmt_waitrequest) begin
                        read_d = 1'b0;
                        if (mgmt_readdata[0]) begin
                            state_d = S_WAIT_LOCK;
                        end else begin
                            if (poll_cnt_q != PW'(POLL_MAX)) begin
                                poll_cnt_d = poll_cnt_q + 1'b1;
                            end
                            if (poll_cnt_q >= PW'(POLL_MAX - 1)) begin
                                state_d    = S_FIN;
                                busy_d     = 1'b0;
                                err_d      = 1'b1;
                                err_code_d = 2'b01;
                            end
                        end
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_sync_q) begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (lock_cnt_q == LW'(LOCK_TIMEOUT)) begin
                        state_d    = S_FIN;
                        busy_d     = 1'b0;
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and registered outputs; reset aborts any sequence at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            poll_cnt_q <= '0;
            lock_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            n_q        <= '0;
            m_q        <= '0;
            c0_q       <= '0;
            k_q        <= '0;
            frac_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            read_q     <= read_d;
            poll_cnt_q <= poll_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            n_q        <= n_d;
            m_q        <= m_d;
            c0_q       <= c0_d;
            k_q        <= k_d;
            frac_q     <= frac_d;
        end
    end

    assign mgmt_address   = addr_q;
    assign mgmt_writedata = wdata_q;
    assign mgmt_write     = write_q;
    assign mgmt_read      = read_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign err_code       = err_code_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb/tb_pll_reconfig_ctrl.sv - randomized self-checking bench for pll_reconfig_ctrl
module tb_pll_reconfig_ctrl;

    localparam int POLL_MAX     = 4;
    localparam int LOCK_TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [17:0] cfg_n = '0, cfg_m = '0, cfg_c0 = '0;
    logic [31:0] cfg_k = '0;
    logic        cfg_frac_en = 1'b0;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_write, mgmt_read;
    logic [31:0] mgmt_readdata = '0;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b0;
    logic        busy, done, err;
    logic [1:0]  err_code;

    pll_reconfig_ctrl #(
        .ADDR_W(6), .DATA_W(32), .LOCK_TIMEOUT(LOCK_TIMEOUT), .POLL_MAX(POLL_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c0(cfg_c0), .cfg_k(cfg_k), .cfg_frac_en(cfg_frac_en),
        .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
        .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
        .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked(pll_locked), .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Management-port slave model: stalls, logs accepted accesses, answers status reads.
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          rd_count = 0;
    int          stall_cfg = 0;
    int          stall_left = 0;
    bit          in_acc = 0;
    bit          acc_prev = 0;
    logic [5:0]  held_addr;
    logic [31:0] held_data;
    logic        held_wr;
    int          zeros_left = 0;
    int          lock_delay = 0;
    int          lock_cd = 0;
    int          cyc = 0;
    int          succ_cyc = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (lock_cd > 0) begin
            lock_cd--;
            if (lock_cd == 0) pll_locked = 1'b1;
        end
        if (!rst_n) begin
            in_acc = 0;
            acc_prev = 0;
            mgmt_waitrequest = 1'b0;
        end else begin
            if (acc_prev) check("idle_gap", {63'd0, mgmt_write | mgmt_read}, 64'd0);
            acc_prev = 0;
            if (mgmt_write || mgmt_read) begin
                check("rw_exclusive", {63'd0, mgmt_write & mgmt_read}, 64'd0);
                if (!in_acc) begin
                    in_acc     = 1;
                    stall_left = stall_cfg;
                    held_addr  = mgmt_address;
                    held_data  = mgmt_writedata;
                    held_wr    = mgmt_write;
                end else begin
                    check("stall_addr", {58'd0, mgmt_address}, {58'd0, held_addr});
                    check("stall_strobe", {63'd0, mgmt_write}, {63'd0, held_wr});
                    if (held_wr) check("stall_data", {32'd0, mgmt_writedata}, {32'd0, held_data});
                end
                if (stall_left > 0) begin
                    mgmt_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    in_acc   = 0;
                    acc_prev = 1;
                    if (mgmt_write) begin
                        wa_q.push_back({26'd0, mgmt_address});
                        wd_q.push_back(mgmt_writedata);
                    end else begin
                        rd_count++;
                        check("rd_addr", {58'd0, mgmt_address}, 64'd1);
                        if (zeros_left > 0) begin
                            mgmt_readdata = $urandom() & 32'hFFFF_FFFE;
                            zeros_left--;
                        end else begin
                            mgmt_readdata = $urandom() | 32'h1;
                            succ_cyc = cyc;
                            if (lock_delay >= 0) lock_cd = lock_delay + 1;
                        end
                    end
                end
            end else begin
                mgmt_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    // One retune with expected behaviour derived from the register map and timeout rules.
    task automatic run_seq(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c,
                           input logic [31:0] k, input logic frac, input int zeros,
                           input int ldly, input int stall, input bit poke);
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        int          exp_reads;
        logic [1:0]  exp_code;
        int          dones;
        int          fin_cyc;
        int          k_seen;
        bit          finished;

        exp_a.push_back(32'h0); exp_d.push_back(32'd1);
        exp_a.push_back(32'h3); exp_d.push_back(32'(n));
        exp_a.push_back(32'h4); exp_d.push_back(32'(m));
        exp_a.push_back(32'h5); exp_d.push_back(32'(c));
        if (frac) begin exp_a.push_back(32'h7); exp_d.push_back(k); end
        exp_a.push_back(32'h2); exp_d.push_back(32'd0);
        if (zeros >= POLL_MAX) begin exp_code = 2'b01; exp_reads = POLL_MAX;   end
        else if (ldly < 0)     begin exp_code = 2'b10; exp_reads = zeros + 1; end
        else                   begin exp_code = 2'b00; exp_reads = zeros + 1; end

        pll_locked = 1'b0;
        wa_q.delete(); wd_q.delete();
        rd_count = 0; zeros_left = zeros; lock_delay = ldly; lock_cd = 0; stall_cfg = stall;
        cfg_n = n; cfg_m = m; cfg_c0 = c; cfg_k = k; cfg_frac_en = frac;
        pulse_start();
        cfg_n = 18'($urandom()); cfg_m = 18'($urandom()); cfg_c0 = 18'($urandom());
        cfg_k = $urandom(); cfg_frac_en = ~frac;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("err_cleared", {63'd0, err}, 64'd0);
        check("code_cleared", {62'd0, err_code}, 64'd0);

        dones = 0; fin_cyc = 0; finished = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #3;
            if (done) dones++;
            if (!busy) begin
                fin_cyc  = cyc;
                finished = 1;
                start    = poke;
                break;
            end
            if (poke) start = 1'($urandom_range(0, 1));
        end
        check("completed", {63'd0, finished}, 64'd1);
        @(posedge clk); #3;
        start = 1'b0;
        if (done) dones++;
        repeat (5) begin
            @(posedge clk); #3;
            if (done) dones++;
        end

        check("busy_idle", {63'd0, busy}, 64'd0);
        check("done_count", 64'(dones), (exp_code == 2'b00) ? 64'd1 : 64'd0);
        check("err_sticky", {63'd0, err}, (exp_code != 2'b00) ? 64'd1 : 64'd0);
        check("err_code", {62'd0, err_code}, {62'd0, exp_code});
        check("read_count", 64'(rd_count), 64'(exp_reads));
        check("write_count", 64'(wa_q.size()), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
            check($sformatf("wr_addr[%0d]", i), {32'd0, wa_q[i]}, {32'd0, exp_a[i]});
            check($sformatf("wr_data[%0d]", i), {32'd0, wd_q[i]}, {32'd0, exp_d[i]});
        end
        k_seen = 0;
        foreach (wa_q[i]) if (wa_q[i] == 32'h7) k_seen++;
        check("k_access", 64'(k_seen), frac ? 64'd1 : 64'd0);
        if (exp_code == 2'b10) begin
            check("lock_timeout_window",
                  {63'd0, (fin_cyc - succ_cyc >= LOCK_TIMEOUT) && (fin_cyc - succ_cyc <= LOCK_TIMEOUT + 4)},
                  64'd1);
        end
    endtask

    task automatic reset_mid();
        int  snap;
        bit  hit;
        wa_q.delete(); wd_q.delete();
        pll_locked = 1'b0; zeros_left = 0; lock_delay = 0; lock_cd = 0; stall_cfg = 3;
        cfg_n = 18'h1_0203; cfg_m = 18'h0_0505; cfg_c0 = 18'h0_0101; cfg_k = 32'h1234_5678; cfg_frac_en = 1'b1;
        pulse_start();
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #3;
            if (mgmt_write && mgmt_address == 6'h4) begin hit = 1; break; end
        end
        check("reach_wr_m", {63'd0, hit}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {19'd0, busy, done, err, err_code, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        snap = wa_q.size();
        repeat (20) @(posedge clk);
        #3;
        check("idle_after_reset", {62'd0, busy, mgmt_write | mgmt_read}, 64'd0);
        check("no_writes_after_reset", 64'(wa_q.size()), 64'(snap));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("reset_outputs",
              {19'd0, busy, done, err, err_code, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata}, 64'd0);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_seq(18'h10000, 18'h00404, 18'h00303, 32'h4189374C, 1'b1, 0, 10, 0, 0);
        run_seq(18'h20A0B, 18'h00606, 18'h10202, 32'hDEADBEEF, 1'b0, 0, 5, 3, 0);
        run_seq(18'h00101, 18'h00808, 18'h00404, 32'h0000_0001, 1'b1, 3, 5, 0, 0);
        run_seq(18'h00101, 18'h00808, 18'h00404, 32'h0000_0002, 1'b1, 4, 5, 1, 0);
        run_seq(18'h00101, 18'h00808, 18'h00404, 32'h0000_0003, 1'b0, 0, -1, 0, 0);
        run_seq(18'h00202, 18'h00909, 18'h00505, 32'h0000_0004, 1'b1, 1, 3, 2, 0);
        reset_mid();
        run_seq(18'h10000, 18'h00404, 18'h00303, 32'h4189374C, 1'b1, 0, 10, 1, 1);

        for (int r = 0; r < 10; r++) begin
            run_seq(18'($urandom()), 18'($urandom()), 18'($urandom()), $urandom(),
                    1'($urandom_range(0, 1)), $urandom_range(0, 5),
                    ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, 30),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
- Sequences a run-time retune of the Cyclone V fractional system PLL (50 MHz ref, 68.8 MHz outclk_0) through the PLL reconfiguration IP's Avalon-MM management port.
- Host logic latches new N/M/C0/K settings and pulses start. The block writes the registers in a fixed order, triggers reconfiguration, polls for completion, waits for lock, then reports done or error.
- Sits between the NMR control register bank and the PLL reconfig core (mgmt side clocked from clk).

Parameters:
- ADDR_W, 6, management address width.
- DATA_W, 32, management data width.
- LOCK_TIMEOUT, 65535, clk cycles allowed for pll_locked after reconfig done.
- POLL_MAX, 1023, maximum status reads before declaring a reconfig timeout.

Ports:
- clk  in  1  system/management clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; ignored while busy.
- cfg_n  in  18  N counter word: [17] odd-duty, [16] bypass, [15:8] hi, [7:0] lo.
- cfg_m  in  18  M counter word, same format.
- cfg_c0  in  18  C0 counter word, same format; the counter select bits [22:18]=0 are inserted by the block.
- cfg_k  in  32  fractional K value.
- cfg_frac_en  in  1  1 = write K register; 0 = skip it.
- mgmt_address  out  ADDR_W  to reconfig core.
- mgmt_writedata  out  DATA_W  to reconfig core.
- mgmt_write  out  1  write strobe.
- mgmt_read  out  1  read strobe.
- mgmt_readdata  in  DATA_W  from reconfig core.
- mgmt_waitrequest  in  1  from reconfig core.
- pll_locked  in  1  PLL locked; asynchronous to clk.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag; cleared by the next accepted start.
- err_code  out  2  00 none, 01 poll timeout, 10 lock timeout.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters cleared. Reset asserted mid-sequence aborts immediately; outputs go to 0 within the same cycle (async).
- Start acceptance: start is accepted only in IDLE. On acceptance, cfg_* are latched into shadow registers; later changes to cfg_* have no effect until the next start. On the cycle after acceptance: busy=1, err=0, err_code=00.
- Register map (word addresses): mode 0x00, status 0x01, start 0x02, N 0x03, M 0x04, C 0x05, K 0x07.
- FSM: IDLE -> WR_MODE(0x00, data 1 = polling mode) -> WR_N -> WR_M -> WR_C0 -> WR_K (skipped when cfg_frac_en=0) -> WR_START(0x02, data 0) -> RD_STATUS -> WAIT_LOCK -> FIN -> IDLE.
- Write data formats:
  - N, M: zero-extended counter word.
  - C0: {9'b0, 5'd0, word} (select bits [22:18]=0).
  - K: cfg_k.
- Write handshake: address, writedata and mgmt_write are registered and held stable until the first cycle where mgmt_write=1 and mgmt_waitrequest=0. Next cycle: write deasserts, FSM advances. Consecutive writes have at least one idle cycle between them. mgmt_read and mgmt_write are never both 1.
- RD_STATUS handshake:
  - Assert mgmt_read at 0x01 and hold until waitrequest=0; sample mgmt_readdata in that cycle.
  - readdata[0]=1: go to WAIT_LOCK.
  - readdata[0]=0: deassert read for one cycle, increment poll count, reissue.
  - If the poll count reaches POLL_MAX while readdata[0] is still 0: go to FIN with err=1, err_code=01.
- pll_locked: passes through a 2-flop synchronizer (adds 2 cycles of latency). WAIT_LOCK exits on synchronized lock=1. A cycle counter runs from 0; when it equals LOCK_TIMEOUT without lock, go to FIN with err=1, err_code=10.
- FIN: busy drops to 0. done=1 for one cycle only if err=0. Return to IDLE on the next cycle. A start arriving in the FIN cycle is ignored.
- Counters saturate; they never wrap.

Test Plan:
- Nominal retune: cfg_n=0x10000, cfg_m=0x00404, cfg_c0=0x00303, cfg_k=0x4189374C, frac_en=1, waitrequest=0, status reads 1 on the first read, locked rises 10 cycles later -> writes observed in order to 0x00,0x03,0x04,0x05,0x07,0x02; one read of 0x01; done pulses once; err=0.
- frac_en=0 with waitrequest held high 3 cycles on each access -> no access to 0x07; address/data stable throughout each stall; exactly one accepted transaction per register.
- Status returns 0 three times, then 1 -> exactly 4 reads, with read deasserted one cycle between them; completes normally.
- POLL_MAX=4, status always 0 -> 4 reads, err=1, err_code=01, no done pulse, busy falls.
- LOCK_TIMEOUT=100, locked held low -> err_code=10 roughly 102 cycles after status done; then a new start clears err and a good retune completes.
- rst_n pulsed low during WR_M, plus start pulses issued while busy -> all outputs 0 immediately; after release the FSM is idle; starts while busy produce no extra sequence.
